// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: FSM state encoding, counter width and the
// grouped pipeline-control vector used by the hazard unit.
package hazard_unit_pkg;

   // Hazard-unit FSM encoding, kept as plain constants so older consumers
   // of this package that compare raw state bits keep working.
   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Width of the performance counters.
   localparam int CNT_W = 32;

   // Width of a register specifier.
   localparam int REG_W = 5;

   // Pipeline control outputs grouped so the decode logic can assign one
   // named constant per situation.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

   // Nothing held, nothing squashed.
   localparam ctrl_t CTRL_NONE  = '{pc_stall: 1'b0, if_id_stall: 1'b0,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0};

   // Hold PC and IF/ID, inject a bubble into EX.
   localparam ctrl_t CTRL_STALL = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b1};

   // Squash the wrong-path instruction sitting in IF/ID.
   localparam ctrl_t CTRL_FLUSH = '{pc_stall: 1'b0, if_id_stall: 1'b0,
                                    if_id_flush: 1'b1, id_ex_flush: 1'b0};

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_reg_match.sv
// Single source/destination comparator. A match means the instruction in
// ID reads a register that an older instruction is still going to write.
// Register 0 is hardwired to zero, so writes to it never create a hazard.
module reg_match
   import hazard_unit_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             use_src,
   input  logic [REG_W-1:0] dst,
   input  logic             we,
   output logic             match
);

   logic write_hazard;

   // A destination is only dangerous when it is really written and non-zero.
   assign write_hazard = we && (dst != '0);

   // The reader must actually consume the operand for the match to count.
   assign match = write_hazard && use_src && (src == dst);

endmodule : reg_match

// File: rtl/hazard_unit.sv
// Pipeline hazard unit for a 5-stage MIPS-like core with branches and
// jump-register resolved in ID. Produces stall/flush controls, a RUN/HALT
// state for halting syscalls, and stall/flush performance counters.
module hazard_unit
   import hazard_unit_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,

   // Instruction in ID
   input  logic [REG_W-1:0] ID_rs,
   input  logic [REG_W-1:0] ID_rt,
   input  logic             ID_use_rs,
   input  logic             ID_use_rt,
   input  logic             ID_branch,
   input  logic             ID_jr,
   input  logic             ID_taken,

   // Older instructions in EX and MEM
   input  logic [REG_W-1:0] EX_RW,
   input  logic [REG_W-1:0] MEM_RW,
   input  logic             EX_regwe,
   input  logic             MEM_regwe,
   input  logic             EX_ramtoreg,
   input  logic             MEM_ramtoreg,

   // Halt / restart
   input  logic             EX_halt,
   input  logic             resume,

   // Pipeline control
   output logic             PC_stall,
   output logic             IF_ID_stall,
   output logic             IF_ID_flush,
   output logic             ID_EX_flush,
   output logic             halted,

   // Performance counters
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   // ------------------------------------------------------------------
   // Source/destination comparisons
   // ------------------------------------------------------------------
   logic ex_rs_match;
   logic ex_rt_match;
   logic mem_rs_match;
   logic mem_rt_match;

   reg_match u_ex_rs (
      .src     (ID_rs),
      .use_src (ID_use_rs),
      .dst     (EX_RW),
      .we      (EX_regwe),
      .match   (ex_rs_match)
   );

   reg_match u_ex_rt (
      .src     (ID_rt),
      .use_src (ID_use_rt),
      .dst     (EX_RW),
      .we      (EX_regwe),
      .match   (ex_rt_match)
   );

   reg_match u_mem_rs (
      .src     (ID_rs),
      .use_src (ID_use_rs),
      .dst     (MEM_RW),
      .we      (MEM_regwe),
      .match   (mem_rs_match)
   );

   reg_match u_mem_rt (
      .src     (ID_rt),
      .use_src (ID_use_rt),
      .dst     (MEM_RW),
      .we      (MEM_regwe),
      .match   (mem_rt_match)
   );

   // ------------------------------------------------------------------
   // Data hazard classification
   // ------------------------------------------------------------------
   logic ex_match;
   logic mem_match;
   logic id_resolves;
   logic load_use;
   logic branch_ex;
   logic branch_mem;
   logic data_stall;

   assign ex_match    = ex_rs_match  || ex_rt_match;
   assign mem_match   = mem_rs_match || mem_rt_match;
   assign id_resolves = ID_branch    || ID_jr;

   // Load in EX: its data exists only after MEM, so any consumer waits.
   assign load_use   = EX_ramtoreg && ex_match;

   // Branch/jr compares in ID, so even an ALU result still in EX is too late.
   assign branch_ex  = id_resolves && ex_match;

   // Load in MEM: data is still in the RAM read path and cannot reach ID.
   // An ALU result in MEM is forwardable and needs no stall.
   assign branch_mem = id_resolves && MEM_ramtoreg && mem_match;

   assign data_stall = load_use || branch_ex || branch_mem;

   // ------------------------------------------------------------------
   // RUN / HALT state
   // ------------------------------------------------------------------
   logic [0:0] state;
   logic [0:0] state_next;

   // Next-state: a halting syscall in EX stops the core, resume restarts it.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_RUN:  if (EX_halt) state_next = ST_HALT;
         ST_HALT: if (resume)  state_next = ST_RUN;
         default:              state_next = ST_RUN;
      endcase
   end

   // State register; reset always lands in RUN, dropping any pending resume.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others; blocking (=) would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_next;
   end

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   ctrl_t ctrl;

   // Pick one control pattern per cycle; a data stall outranks a taken
   // branch so the branch is never resolved on stale operands.
   // NOTE: ctrl gets a default before any branch so every path assigns it;
   // without that the always_comb would infer a latch.
   always_comb begin
      ctrl = CTRL_NONE;
      if (state == ST_HALT) begin
         ctrl = CTRL_STALL;
      end else if (data_stall) begin
         ctrl = CTRL_STALL;
      end else if (ID_taken) begin
         ctrl = CTRL_FLUSH;
      end
   end

   assign PC_stall    = ctrl.pc_stall;
   assign IF_ID_stall = ctrl.if_id_stall;
   assign IF_ID_flush = ctrl.if_id_flush;
   assign ID_EX_flush = ctrl.id_ex_flush;
   assign halted      = (state == ST_HALT);

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   logic stall_inc;
   logic flush_inc;

   // Only genuine data stalls count; the frozen pipeline in HALT does not.
   assign stall_inc = (state == ST_RUN) && data_stall;
   assign flush_inc = ctrl.if_id_flush;

   // Counters add 0 or 1 every cycle and wrap silently at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         stall_count <= stall_count + CNT_W'(stall_inc);
         flush_count <= flush_count + CNT_W'(flush_inc);
      end
   end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the driver applies one directed vector
// per cycle and queues its hand-computed expectation; a monitor on the
// falling edge pops and compares controls, halted and both counters.
module tb_hazard_unit;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ID_rs, ID_rt, EX_RW, MEM_RW;
   logic        ID_use_rs, ID_use_rt, ID_branch, ID_jr, ID_taken;
   logic        EX_regwe, MEM_regwe, EX_ramtoreg, MEM_ramtoreg;
   logic        EX_halt, resume;
   logic        PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, halted;
   logic [31:0] stall_count, flush_count;

   hazard_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ID_rs        (ID_rs),
      .ID_rt        (ID_rt),
      .ID_use_rs    (ID_use_rs),
      .ID_use_rt    (ID_use_rt),
      .ID_branch    (ID_branch),
      .ID_jr        (ID_jr),
      .ID_taken     (ID_taken),
      .EX_RW        (EX_RW),
      .MEM_RW       (MEM_RW),
      .EX_regwe     (EX_regwe),
      .MEM_regwe    (MEM_regwe),
      .EX_ramtoreg  (EX_ramtoreg),
      .MEM_ramtoreg (MEM_ramtoreg),
      .EX_halt      (EX_halt),
      .resume       (resume),
      .PC_stall     (PC_stall),
      .IF_ID_stall  (IF_ID_stall),
      .IF_ID_flush  (IF_ID_flush),
      .ID_EX_flush  (ID_EX_flush),
      .halted       (halted),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control patterns {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, halted}
   localparam logic [4:0] NONE  = 5'b00000;
   localparam logic [4:0] STALL = 5'b11010;
   localparam logic [4:0] FLUSH = 5'b00100;
   localparam logic [4:0] HALT  = 5'b11011;

   typedef struct {
      string       name;
      logic [4:0]  ctrl;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check({mon_e.name, ".ctrl"}, {27'd0, PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, halted},
               {27'd0, mon_e.ctrl});
         check({mon_e.name, ".stall_count"}, stall_count, mon_e.sc);
         check({mon_e.name, ".flush_count"}, flush_count, mon_e.fc);
      end
   end

   task automatic clr();
      ID_rs = 0; ID_rt = 0; ID_use_rs = 0; ID_use_rt = 0;
      ID_branch = 0; ID_jr = 0; ID_taken = 0;
      EX_RW = 0; MEM_RW = 0; EX_regwe = 0; MEM_regwe = 0;
      EX_ramtoreg = 0; MEM_ramtoreg = 0; EX_halt = 0; resume = 0;
   endtask

   // Queue the expectation for the inputs now applied, then move to the
   // next cycle (1 time unit after the rising edge).
   task automatic expect_cycle(input string name, input logic [4:0] ctrl,
                               input logic [31:0] sc, input logic [31:0] fc);
      exp_t e;
      e.name = name; e.ctrl = ctrl; e.sc = sc; e.fc = fc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic ex_load(input logic [4:0] rw);
      EX_RW = rw; EX_regwe = 1; EX_ramtoreg = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clr();
      @(posedge clk); #1;

      // Reset
      expect_cycle("reset_held", NONE, 0, 0);
      rst_n = 1'b1;
      expect_cycle("reset_released", NONE, 0, 0);

      // Load-use: lw $8 in EX, add reading rs=8 in ID
      ex_load(8); ID_rs = 8; ID_use_rs = 1;
      expect_cycle("load_use", STALL, 0, 0);
      clr();
      expect_cycle("load_use_done", NONE, 1, 0);

      // Load feeding beq rt=9: EX stall then MEM stall
      ex_load(9); ID_rt = 9; ID_use_rt = 1; ID_branch = 1;
      expect_cycle("ld_branch_ex", STALL, 1, 0);
      EX_RW = 0; EX_regwe = 0; EX_ramtoreg = 0;
      MEM_RW = 9; MEM_regwe = 1; MEM_ramtoreg = 1;
      expect_cycle("ld_branch_mem", STALL, 2, 0);
      clr();
      expect_cycle("ld_branch_done", NONE, 3, 0);

      // ALU feeding jr: one stall only, then forwardable from MEM
      EX_RW = 5; EX_regwe = 1; ID_rs = 5; ID_use_rs = 1; ID_jr = 1;
      expect_cycle("alu_jr_ex", STALL, 3, 0);
      EX_RW = 0; EX_regwe = 0; MEM_RW = 5; MEM_regwe = 1;
      expect_cycle("alu_jr_mem", NONE, 4, 0);

      // Load in MEM feeding a non-branch: forwarding covers it
      clr(); MEM_RW = 6; MEM_regwe = 1; MEM_ramtoreg = 1; ID_rs = 6; ID_use_rs = 1;
      expect_cycle("mem_load_alu", NONE, 4, 0);

      // Register 0 never hazards; resume in RUN is ignored
      clr(); ex_load(0); ID_rs = 0; ID_use_rs = 1; ID_branch = 1; resume = 1;
      expect_cycle("reg_zero", NONE, 4, 0);

      // Unused source and disabled write enable do not hazard
      clr(); ex_load(7); ID_rt = 7; ID_use_rt = 0; ID_branch = 1;
      expect_cycle("unused_src", NONE, 4, 0);
      clr(); EX_RW = 7; EX_ramtoreg = 1; EX_regwe = 0; ID_rt = 7; ID_use_rt = 1; ID_branch = 1;
      expect_cycle("no_regwe", NONE, 4, 0);

      // Stall beats taken branch; next cycle taken alone flushes
      clr(); ex_load(8); ID_rs = 8; ID_use_rs = 1; ID_branch = 1; ID_taken = 1;
      expect_cycle("stall_over_taken", STALL, 4, 0);
      clr(); ID_branch = 1; ID_taken = 1;
      expect_cycle("taken_flush", FLUSH, 5, 0);
      clr();
      expect_cycle("flush_counted", NONE, 5, 1);

      // Halt: the EX_halt cycle still behaves as RUN (taken flush here)
      EX_halt = 1; ID_taken = 1;
      expect_cycle("halt_entry", FLUSH, 5, 1);
      clr();
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) begin
            ex_load(3); ID_rs = 3; ID_use_rs = 1; ID_branch = 1;
         end else begin
            clr(); ID_taken = 1;
         end
         expect_cycle($sformatf("halt_hold%0d", i), HALT, 5, 2);
      end
      clr(); resume = 1;
      expect_cycle("halt_resume", HALT, 5, 2);
      clr();
      expect_cycle("after_resume", NONE, 5, 2);

      // Reset while halted with a resume pending
      EX_halt = 1;
      expect_cycle("halt2_entry", NONE, 5, 2);
      clr();
      expect_cycle("halt2_held", HALT, 5, 2);
      rst_n = 1'b0; resume = 1;
      expect_cycle("reset_in_halt", NONE, 0, 0);
      expect_cycle("reset_in_halt_held", NONE, 0, 0);
      rst_n = 1'b1; resume = 0;
      expect_cycle("reset_exit", NONE, 0, 0);
      expect_cycle("run_after_reset", NONE, 0, 0);

      // Stall counter wrap: the preload is held across one idle edge so the
      // counter itself latches the all-ones value before release.
      force dut.stall_count = 32'hFFFF_FFFF;
      expect_cycle("wrap_preload", NONE, 32'hFFFF_FFFF, 0);
      release dut.stall_count;
      ex_load(4); ID_rt = 4; ID_use_rt = 1;
      expect_cycle("wrap_stall", STALL, 32'hFFFF_FFFF, 0);
      clr();
      expect_cycle("wrap_zero", NONE, 0, 0);

      @(negedge clk); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_hazard_unit
